// File: rtl/alu_pkg.sv
// Shared ALU op encodings and the multiplier's state type.
package alu_pkg;

   // ALU op word: [0] add enable, [1] subtract (invert b, force carry-in),
   // [2] carry-in, [3] shift-left enable, [4] bitwise truth-table enable.
   localparam logic [4:0] ALU_OP_NOP   = 5'b00000;
   localparam logic [4:0] ALU_OP_ADD   = 5'b00001;
   localparam logic [4:0] ALU_OP_SUB   = 5'b00011;
   localparam logic [4:0] ALU_OP_ADDC  = 5'b00101;
   localparam logic [4:0] ALU_OP_SHL   = 5'b01000;
   localparam logic [4:0] ALU_OP_LOGIC = 5'b10000;

   localparam int unsigned OP_W  = 5;
   localparam int unsigned DAT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADD   = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } mul_state_e;

endpackage

// File: rtl/alu.sv
// 16-bit combinational ALU: add/sub with carry, left shift, bitwise LUT.
module alu
   import alu_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [4:0]  op,
   input  logic [3:0]  sh_off,
   input  logic [3:0]  truth_table,
   output logic [15:0] out,
   output logic        flag_carry
);

   logic [15:0] b_eff;
   logic [16:0] sum;
   logic        cin;

   // Select one function by op priority; defaults keep everything latch-free.
   always_comb begin
      out        = '0;
      flag_carry = 1'b0;
      b_eff      = op[1] ? ~b : b;
      cin        = op[1] | op[2];
      sum        = {1'b0, a} + {1'b0, b_eff} + {16'b0, cin};
      if (op[0]) begin
         out        = sum[15:0];
         flag_carry = sum[16];
      end else if (op[3]) begin
         out = a << sh_off;
      end else if (op[4]) begin
         for (int i = 0; i < 16; i++) begin
            out[i] = truth_table[{a[i], b[i]}];
         end
      end
   end

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential 16x16 unsigned shift-add multiplier; every add goes through alu.
module alu_mul_seq
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] mcand,
   input  logic [15:0] mplier,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] product,
   output logic        busy
);

   mul_state_e  state_q, state_d;
   logic [15:0] mc_q, mc_d;
   logic [15:0] hi_q, hi_d;
   logic [15:0] lo_q, lo_d;
   logic        c_q, c_d;
   logic [3:0]  cnt_q, cnt_d;

   logic [15:0] alu_out;
   logic        alu_carry;

   // The ALU is hard-wired as hi + mc; ADD decides whether to keep the sum.
   alu u_alu (
      .a           (hi_q),
      .b           (mc_q),
      .op          (ALU_OP_ADD),
      .sh_off      (4'd0),
      .truth_table (4'd0),
      .out         (alu_out),
      .flag_carry  (alu_carry)
   );

   // Outputs decode straight from registered state: no input-to-output paths.
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_ADD) || (state_q == ST_SHIFT);
   assign product   = {hi_q, lo_q};

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      mc_d    = mc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               mc_d    = mcand;
               lo_d    = mplier;
               hi_d    = '0;
               c_d     = 1'b0;
               cnt_d   = '0;
               state_d = ST_ADD;
            end
         end
         ST_ADD: begin
            if (lo_q[0]) begin
               {c_d, hi_d} = {alu_carry, alu_out};
            end else begin
               c_d = 1'b0;
            end
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            // 33-bit logical right shift of {c,hi,lo}
            {c_d, hi_d, lo_d} = {1'b0, c_q, hi_q, lo_q[15:1]};
            cnt_d   = cnt_q + 4'd1;
            state_d = (cnt_q == 4'd15) ? ST_DONE : ST_ADD;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register with synchronous reset that clears all datapath state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mc_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mc_q    <= mc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with an expected-product scoreboard.
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] mcand;
   logic [15:0] mplier;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] product;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   alu_mul_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mcand     (mcand),
      .mplier    (mplier),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
   endtask

   // Accept one operand pair, optionally pulse in_valid mid-operation, wait
   // for the product, hold it for 'hold' cycles, then consume it.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input int pulse_at, input int hold);
      int          lat;
      logic [31:0] exp;
      exp_q.push_back(32'(a) * 32'(b));
      in_valid = 1'b1; mcand = a; mplier = b;
      tick();
      in_valid = 1'b0; mcand = 16'($urandom); mplier = 16'($urandom);
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("in_ready_after_accept", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 64) begin
         if (lat == pulse_at) begin
            in_valid = 1'b1; mcand = 16'h0F0F; mplier = 16'h0F0F;
         end
         tick();
         in_valid = 1'b0;
         lat++;
      end
      chk("latency", 32'(lat), 32'd32);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         exp = 'x;
      end else begin
         exp = exp_q.pop_front();
      end
      chk("product", product, exp);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_product", product, exp);
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      // consume while offering new operands: DONE must not accept them
      out_ready = 1'b1; in_valid = 1'b1; mcand = 16'h1111; mplier = 16'h2222;
      tick();
      out_ready = 1'b0; in_valid = 1'b0;
      check_idle("after_consume");
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mcand = '0; mplier = '0;
      tick(); tick();
      rst = 1'b0;
      check_idle("reset");
      chk("reset_product", product, 32'h0);

      // reset wins over a simultaneous handshake
      rst = 1'b1; in_valid = 1'b1; mcand = 16'h0005; mplier = 16'h0006;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      check_idle("rst_vs_accept");

      run_op(16'h0003, 16'h0005, -1, 0);
      run_op(16'hFFFF, 16'hFFFF, -1, 0);
      run_op(16'h1234, 16'h0000, -1, 0);
      run_op(16'h0000, 16'hABCD, -1, 0);
      run_op(16'h8000, 16'h0002, -1, 10);
      run_op(16'h0003, 16'h0005, 5, 0);
      run_op(16'hA5C3, 16'h3C5A, 20, 2);

      // abort mid-operation
      in_valid = 1'b1; mcand = 16'h00FF; mplier = 16'h0101;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      chk("busy_before_abort", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("abort");
      chk("abort_product", product, 32'h0);
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid) chk("abort_no_output", 32'(out_valid), 32'd0);
      end
      chk("abort_stays_idle", 32'(in_ready), 32'd1);
      run_op(16'd7, 16'd9, -1, 0);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
